// File: rtl/usb_fs_rx.sv
// usb_fs_rx: full-speed USB receiver front end (synchroniser, DPLL, NRZI, unstuffing, EOP).
// Optional build macro USB_FS_RX_GLITCH_FILTER_EN: line state must hold 2 cycles before acceptance.
module usb_fs_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usb_dp_rx_i,
  input  logic       usb_dn_rx_i,
  input  logic       rx_en,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_active_o,
  output logic       rx_eop_o,
  output logic       rx_err_o,
  output logic [1:0] line_state_o
);

  localparam logic [1:0] LS_SE0 = 2'd0;
  localparam logic [1:0] LS_J   = 2'd1;
  localparam logic [1:0] LS_K   = 2'd2;
  localparam logic [1:0] LS_SE1 = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERR} state_t;

  // The last synchroniser flop is ls_reg itself, so the chain holds SYNC_STAGES-1 flops.
  logic [1:0] sync_reg [SYNC_STAGES-1];
  logic [1:0] raw_ls;
  logic [1:0] ls_reg, ls_next;
  logic [1:0] phase_reg;
  logic       strobe, is_jk, nrzi_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES-1; i++) sync_reg[i] <= 2'b00;
    end else begin
      sync_reg[0] <= {usb_dn_rx_i, usb_dp_rx_i};
      for (int i = 1; i < SYNC_STAGES-1; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign raw_ls = sync_reg[SYNC_STAGES-2];

`ifdef USB_FS_RX_GLITCH_FILTER_EN
  logic [1:0] raw_hold_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) raw_hold_reg <= 2'b00;
    else        raw_hold_reg <= raw_ls;
  end

  // Accept only when the value has been seen on two consecutive cycles.
  assign ls_next = (raw_ls == raw_hold_reg) ? raw_ls : ls_reg;
`else
  assign ls_next = raw_ls;
`endif

  // Phase restarts on the same edge the decoded state changes, so phase 2 lands mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_reg    <= 2'b00;
      phase_reg <= 2'd0;
    end else begin
      ls_reg    <= ls_next;
      phase_reg <= (ls_next != ls_reg) ? 2'd0 : phase_reg + 2'd1;
    end
  end

  assign line_state_o = ls_reg;

  state_t     state_reg, state_next;
  logic [1:0] prev_jk_reg, prev_jk_next;
  logic [2:0] zero_cnt_reg, zero_cnt_next;
  logic [2:0] ones_cnt_reg, ones_cnt_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0] j_cnt_reg, j_cnt_next;
  logic [1:0] se0_cnt_reg, se0_cnt_next;
  logic       se0_seen_reg, se0_seen_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] data_reg, data_next;
  logic       valid_reg, valid_next;
  logic       eop_reg, eop_next;
  logic       err_reg, err_next;
  logic       active_reg, active_next;

  assign strobe   = (phase_reg == 2'd2);
  assign is_jk    = (ls_reg == LS_J) || (ls_reg == LS_K);
  assign nrzi_bit = (ls_reg == prev_jk_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      prev_jk_reg  <= LS_J;
      zero_cnt_reg <= 3'd0;
      ones_cnt_reg <= 3'd0;
      bit_cnt_reg  <= 3'd0;
      j_cnt_reg    <= 3'd0;
      se0_cnt_reg  <= 2'd0;
      se0_seen_reg <= 1'b0;
      shift_reg    <= 8'h00;
      data_reg     <= 8'h00;
      valid_reg    <= 1'b0;
      eop_reg      <= 1'b0;
      err_reg      <= 1'b0;
      active_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      prev_jk_reg  <= prev_jk_next;
      zero_cnt_reg <= zero_cnt_next;
      ones_cnt_reg <= ones_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      j_cnt_reg    <= j_cnt_next;
      se0_cnt_reg  <= se0_cnt_next;
      se0_seen_reg <= se0_seen_next;
      shift_reg    <= shift_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      eop_reg      <= eop_next;
      err_reg      <= err_next;
      active_reg   <= active_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    prev_jk_next  = prev_jk_reg;
    zero_cnt_next = zero_cnt_reg;
    ones_cnt_next = ones_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    j_cnt_next    = j_cnt_reg;
    se0_cnt_next  = se0_cnt_reg;
    se0_seen_next = se0_seen_reg;
    shift_next    = shift_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    eop_next      = 1'b0;
    err_next      = 1'b0;
    active_next   = active_reg;

    if (strobe) begin
      if (is_jk) prev_jk_next = ls_reg;
      case (state_reg)
        S_IDLE: begin
          if (ls_reg == LS_K) begin
            state_next    = S_SYNC;
            zero_cnt_next = 3'd1;
          end
        end
        S_SYNC: begin
          if (!is_jk) begin
            state_next = S_IDLE;
          end else if (!nrzi_bit) begin
            zero_cnt_next = (zero_cnt_reg == 3'd7) ? 3'd7 : zero_cnt_reg + 3'd1;
          end else if (zero_cnt_reg >= 3'd5) begin
            state_next    = S_DATA;
            active_next   = 1'b1;
            bit_cnt_next  = 3'd0;
            ones_cnt_next = 3'd0;
          end else begin
            state_next = S_IDLE;
          end
        end
        S_DATA: begin
          // SE0 wins over a pending stuff bit, so a stuff slot at packet end is a clean EOP.
          if (ls_reg == LS_SE0) begin
            state_next   = S_EOP;
            se0_cnt_next = 2'd1;
          end else if (ls_reg == LS_SE1 || (ones_cnt_reg == 3'd6 && nrzi_bit)) begin
            state_next    = S_ERR;
            err_next      = 1'b1;
            active_next   = 1'b0;
            j_cnt_next    = 3'd0;
            se0_seen_next = 1'b0;
          end else if (ones_cnt_reg == 3'd6) begin
            ones_cnt_next = 3'd0;
          end else begin
            ones_cnt_next = nrzi_bit ? ones_cnt_reg + 3'd1 : 3'd0;
            shift_next    = {nrzi_bit, shift_reg[7:1]};
            if (bit_cnt_reg == 3'd7) begin
              data_next    = {nrzi_bit, shift_reg[7:1]};
              valid_next   = 1'b1;
              bit_cnt_next = 3'd0;
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end
        end
        S_EOP: begin
          if (ls_reg == LS_SE0) begin
            se0_cnt_next = (se0_cnt_reg == 2'd3) ? 2'd3 : se0_cnt_reg + 2'd1;
          end else if (ls_reg == LS_J) begin
            state_next  = S_IDLE;
            eop_next    = 1'b1;
            active_next = 1'b0;
            err_next    = (bit_cnt_reg != 3'd0) || (se0_cnt_reg < 2'd2);
          end else begin
            state_next    = S_ERR;
            err_next      = 1'b1;
            active_next   = 1'b0;
            j_cnt_next    = 3'd0;
            se0_seen_next = 1'b0;
          end
        end
        S_ERR: begin
          active_next = 1'b0;
          case (ls_reg)
            LS_SE0: begin
              se0_seen_next = 1'b1;
              j_cnt_next    = 3'd0;
            end
            LS_J: begin
              if (se0_seen_reg || j_cnt_reg == 3'd7) state_next = S_IDLE;
              else                                   j_cnt_next = j_cnt_reg + 3'd1;
            end
            default: begin
              se0_seen_next = 1'b0;
              j_cnt_next    = 3'd0;
            end
          endcase
        end
        default: state_next = S_IDLE;
      endcase
    end

    // While the transmitter owns the bus, hold the receiver idle and silent.
    if (!rx_en) begin
      state_next  = S_IDLE;
      active_next = 1'b0;
      valid_next  = 1'b0;
      eop_next    = 1'b0;
      err_next    = 1'b0;
      data_next   = data_reg;
    end
  end

  assign rx_data_o   = data_reg;
  assign rx_valid_o  = valid_reg;
  assign rx_active_o = active_reg;
  assign rx_eop_o    = eop_reg;
  assign rx_err_o    = err_reg;

endmodule

// File: tb/tb_usb_fs_rx.sv
// tb_usb_fs_rx: randomized/directed packets encoded from byte-level intent; a monitor
// checks every strobe against an expected-event queue.
module tb_usb_fs_rx;

  localparam int SYNC = 2;
`ifdef USB_FS_RX_GLITCH_FILTER_EN
  localparam int LAT = SYNC + 1;
`else
  localparam int LAT = SYNC;
`endif

  localparam logic [1:0] LS_SE0 = 2'd0;
  localparam logic [1:0] LS_J   = 2'd1;
  localparam logic [1:0] LS_K   = 2'd2;
  localparam logic [1:0] LS_SE1 = 2'd3;

  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_EOP   = 2'd2;
  localparam logic [1:0] K_ERR   = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic       err;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       usb_dp_rx_i = 1'b1;
  logic       usb_dn_rx_i = 1'b0;
  logic       rx_en = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_active_o;
  logic       rx_eop_o;
  logic       rx_err_o;
  logic [1:0] line_state_o;

  int         checks = 0;
  int         errors = 0;
  int         bit_idx = 0;
  ev_t        exp_q[$];
  logic [7:0] tx_bytes[$];
  bit         data_bits[$];

  usb_fs_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .usb_dp_rx_i  (usb_dp_rx_i),
    .usb_dn_rx_i  (usb_dn_rx_i),
    .rx_en        (rx_en),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_active_o  (rx_active_o),
    .rx_eop_o     (rx_eop_o),
    .rx_err_o     (rx_err_o),
    .line_state_o (line_state_o)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [7:0] data, input logic err);
    ev_t ev;
    ev.kind = kind;
    ev.data = data;
    ev.err  = err;
    exp_q.push_back(ev);
  endtask

  // Bit-level wire image of the payload: LSB first, a 0 inserted after every six 1s.
  task automatic encode(input int nbits, input bit stuff_trailing);
    int ones;
    logic [7:0] byte_v;
    bit b;
    ones = 0;
    data_bits.delete();
    for (int i = 0; i < nbits; i++) begin
      byte_v = tx_bytes[i / 8];
      b = byte_v[i % 8];
      data_bits.push_back(b);
      ones = b ? ones + 1 : 0;
      if (ones == 6 && (i < nbits - 1 || stuff_trailing)) begin
        data_bits.push_back(1'b0);
        ones = 0;
      end
    end
  endtask

  // Expected receiver output for a well-formed packet: every whole byte, then an EOP.
  task automatic expect_packet(input int nbits, input int se0_bits);
    for (int k = 0; k < nbits / 8; k++) push_ev(K_VALID, tx_bytes[k], 1'b0);
    push_ev(K_EOP, 8'h00, (nbits % 8 != 0) || (se0_bits < 2));
  endtask

  task automatic drive_bit(input logic [1:0] ls, input bit jitter);
    int w;
    w = jitter ? ((bit_idx % 2 == 0) ? 3 : 5) : 4;
    bit_idx++;
    {usb_dn_rx_i, usb_dp_rx_i} = ls;
    repeat (w) @(negedge clk);
  endtask

  task automatic send_packet(input bit jitter, input int se0_bits, input int dis_after);
    logic [1:0] lvl;
    bit_idx = 0;
    for (int i = 0; i < 8; i++) drive_bit(LS_J, 1'b0);
    check("idle_active", rx_active_o, 0);
    lvl = LS_J;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) lvl = (lvl == LS_J) ? LS_K : LS_J;
      drive_bit(lvl, jitter);
    end
    for (int i = 0; i < data_bits.size(); i++) begin
      if (!data_bits[i]) lvl = (lvl == LS_J) ? LS_K : LS_J;
      drive_bit(lvl, jitter);
      if (i == 0) check("active_after_sync", rx_active_o, 1);
      if (i + 1 == dis_after) begin
        rx_en = 1'b0;
        @(negedge clk);
        check("active_after_rx_en_low", rx_active_o, 0);
      end
    end
    for (int i = 0; i < se0_bits; i++) drive_bit(LS_SE0, jitter);
    drive_bit(LS_J, jitter);
    for (int i = 0; i < 8; i++) drive_bit(LS_J, 1'b0);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    ev_t ev;
    logic [1:0] kind;
    forever begin
      @(negedge clk);
      if (rst_n && (rx_valid_o || rx_eop_o || rx_err_o)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: valid=%0b eop=%0b err=%0b data=%02h, required no strobe",
                   rx_valid_o, rx_eop_o, rx_err_o, rx_data_o);
        end else begin
          ev = exp_q.pop_front();
          kind = rx_valid_o ? K_VALID : (rx_eop_o ? K_EOP : K_ERR);
          check("event_kind", kind, ev.kind);
          if (ev.kind == K_VALID) begin
            check("rx_data", rx_data_o, ev.data);
            check("valid_no_eop", rx_eop_o, 0);
            check("valid_active", rx_active_o, 1);
          end else if (ev.kind == K_EOP) begin
            check("eop_err", rx_err_o, ev.err);
            check("eop_active_fall", rx_active_o, 0);
          end else begin
            check("err_active_fall", rx_active_o, 0);
          end
          $display("event kind=%0d data=%02h err=%0b (expected kind=%0d data=%02h err=%0b)",
                   kind, rx_data_o, rx_err_o, ev.kind, ev.data, ev.err);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ls_seq [4];
    logic [1:0] prev_ls;
    int nb, se0;
    bit jit;

    repeat (3) @(negedge clk);
    check("reset_data", rx_data_o, 0);
    check("reset_valid", rx_valid_o, 0);
    check("reset_active", rx_active_o, 0);
    check("reset_eop", rx_eop_o, 0);
    check("reset_err", rx_err_o, 0);
    check("reset_line_state", line_state_o, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("idle_line_state", line_state_o, LS_J);

    // Pad-to-line_state latency with the receiver disabled.
    rx_en = 1'b0;
    ls_seq[0] = LS_SE0; ls_seq[1] = LS_K; ls_seq[2] = LS_SE1; ls_seq[3] = LS_J;
    prev_ls = LS_J;
    for (int i = 0; i < 4; i++) begin
      {usb_dn_rx_i, usb_dp_rx_i} = ls_seq[i];
      repeat (LAT - 1) @(negedge clk);
      check("line_state_before_latency", line_state_o, prev_ls);
      @(negedge clk);
      check("line_state_at_latency", line_state_o, ls_seq[i]);
      repeat (4) @(negedge clk);
      prev_ls = ls_seq[i];
    end
    check("no_active_while_disabled", rx_active_o, 0);
    rx_en = 1'b1;
    $display("line state latency sequence done");

    tx_bytes = '{8'hA5};
    encode(8, 1'b1); expect_packet(8, 2);
    $display("pkt A5"); send_packet(1'b0, 2, 0);

    tx_bytes = '{8'hFF, 8'h3F};
    encode(16, 1'b1); expect_packet(16, 2);
    $display("pkt FF 3F stuffed"); send_packet(1'b0, 2, 0);

    data_bits.delete();
    for (int i = 0; i < 8; i++) data_bits.push_back(1'b0);
    for (int i = 0; i < 7; i++) data_bits.push_back(1'b1);
    push_ev(K_VALID, 8'h00, 1'b0);
    push_ev(K_ERR, 8'h00, 1'b1);
    $display("pkt 00 then seven ones"); send_packet(1'b0, 2, 0);

    tx_bytes = '{8'h5A};
    encode(8, 1'b1); expect_packet(8, 2);
    $display("pkt 5A after error"); send_packet(1'b0, 2, 0);

    tx_bytes = '{8'hC3};
    encode(8, 1'b1); expect_packet(8, 2);
    $display("pkt C3 jittered"); send_packet(1'b1, 2, 0);

    tx_bytes = '{8'h96, 8'h05};
    encode(12, 1'b1); expect_packet(12, 2);
    $display("pkt 12 bits"); send_packet(1'b0, 2, 0);

    tx_bytes = '{8'hFC};
    encode(8, 1'b0); expect_packet(8, 2);
    $display("pkt FC, SE0 in stuff slot"); send_packet(1'b0, 2, 0);

    tx_bytes = '{8'h81, 8'h42};
    encode(16, 1'b1);
    $display("pkt 81 42, rx_en low after 4 bits"); send_packet(1'b0, 2, 4);
    rx_en = 1'b1;
    repeat (8) @(negedge clk);

    for (int p = 0; p < 10; p++) begin
      nb  = $urandom_range(1, 4);
      se0 = $urandom_range(1, 3);
      jit = 1'($urandom_range(0, 1));
      tx_bytes.delete();
      for (int k = 0; k < nb; k++)
        tx_bytes.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      encode(nb * 8, 1'b1);
      expect_packet(nb * 8, se0);
      $display("pkt random %0d: bytes=%0d se0=%0d jitter=%0b", p, nb, se0, jit);
      send_packet(jit, se0, 0);
    end

    repeat (40) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
